hack_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single Hack data-memory port (RAM 0x0000–0x3FFF, screen 0x4000–0x5FFF, keyboard 0x6000) between the CPU data path and a DMA requester (HPS loader / screen-fill engine). It sits between the requesters and the memory block and owns every `mem_*` signal. It sequences the accesses, enforces a bounded-burst round-robin policy, and blocks writes while reads are in flight. This blocking is required because the memory output register freezes on any cycle in which `load` is high.

---
 rtl/hack_mem_arbiter_pkg.sv | 21 ++
 rtl/hack_mem_arbiter_if.sv | 44 ++++
 rtl/hack_mem_arbiter_rd_tag_pipe.sv | 38 +++
 rtl/hack_mem_arbiter.sv | 113 +++++++++++
 tb/tb_hack_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_mem_arbiter_pkg.sv
// Shared types and constants for the Hack data-memory arbiter.
// Holds the FSM state enum, port indices and memory-map bases.
package hack_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OWN_CPU,
      ST_OWN_DMA
   } arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   localparam logic [14:0] SCREEN_BASE = 15'h4000;
   localparam logic [14:0] KBD_ADDR    = 15'h6000;

   function automatic arb_state_e own_state(logic port);
      return (port == PORT_DMA) ? ST_OWN_DMA : ST_OWN_CPU;
   endfunction

endpackage

// File: rtl/hack_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and memory.
// slave: arbiter side. master: requesters plus memory block side.
interface hack_mem_arbiter_if;

   logic        cpu_req;
   logic        cpu_we;
   logic [14:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_gnt;
   logic        cpu_rvalid;
   logic [15:0] cpu_rdata;

   logic        dma_req;
   logic        dma_we;
   logic [14:0] dma_addr;
   logic [15:0] dma_wdata;
   logic        dma_gnt;
   logic        dma_rvalid;
   logic [15:0] dma_rdata;

   logic [15:0] mem_in;
   logic        mem_load;
   logic [14:0] mem_address;
   logic [15:0] mem_out;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_in, mem_load, mem_address,
      input  mem_out
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_in, mem_load, mem_address,
      output mem_out
   );

endinterface

// File: rtl/hack_mem_arbiter_rd_tag_pipe.sv
// Read-tag shift register: {valid, port} per issued read.
// Ports: push_i/port_i in, per-port rvalid_o and busy_o out.
module rd_tag_pipe
   import hack_mem_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push_i,
   input  logic port_i,
   output logic cpu_rvalid_o,
   output logic dma_rvalid_o,
   output logic busy_o
);

   localparam int unsigned DEPTH = RD_LAT + 1;

   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] port_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         port_q <= '0;
      end else begin
         vld_q  <= (vld_q << 1) | DEPTH'(push_i);
         port_q <= (port_q << 1) | DEPTH'(port_i);
      end
   end

   assign cpu_rvalid_o = vld_q[DEPTH-1] & (port_q[DEPTH-1] == PORT_CPU);
   assign dma_rvalid_o = vld_q[DEPTH-1] & (port_q[DEPTH-1] == PORT_DMA);

   // Includes the tail: a read is in flight up to its rvalid cycle.
   assign busy_o = |vld_q;

endmodule

// File: rtl/hack_mem_arbiter.sv
// Arbitrates CPU and DMA onto the single Hack data-memory port.
// Ports: clk, reset (async, active-low), bus (slave modport).
module hack_mem_arbiter
   import hack_mem_pkg::*;
#(
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic               clk,
   input  logic               reset,
   hack_mem_arbiter_if.slave  bus
);

   localparam int unsigned CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

   arb_state_e    state_q;
   logic [CW-1:0] burst_q;
   logic [14:0]   addr_q;
   logic [15:0]   wdata_q;
   logic          load_q;

   logic        sel_vld;
   logic        sel_port;
   logic        sel_we;
   logic [14:0] sel_addr;
   logic [15:0] sel_wdata;
   logic        stall;
   logic        gnt_any;
   logic        rd_busy;
   logic        cpu_rv;
   logic        dma_rv;

   always_comb begin
      sel_vld  = bus.cpu_req | bus.dma_req;
      sel_port = PORT_CPU;
      unique case (state_q)
         ST_IDLE:
            sel_port = bus.cpu_req ? PORT_CPU : PORT_DMA;
         ST_OWN_CPU:
            sel_port = (bus.cpu_req &&
                        (!bus.dma_req || burst_q < BURST_MAX))
                       ? PORT_CPU : PORT_DMA;
         ST_OWN_DMA:
            sel_port = (bus.dma_req &&
                        (!bus.cpu_req || burst_q < BURST_MAX))
                       ? PORT_DMA : PORT_CPU;
         default:
            sel_port = PORT_CPU;
      endcase

      sel_we    = (sel_port == PORT_DMA) ? bus.dma_we    : bus.cpu_we;
      sel_addr  = (sel_port == PORT_DMA) ? bus.dma_addr  : bus.cpu_addr;
      sel_wdata = (sel_port == PORT_DMA) ? bus.dma_wdata : bus.cpu_wdata;

      // A write would freeze the memory output register under a read.
      stall   = sel_we & rd_busy;
      gnt_any = sel_vld & ~stall & reset;
   end

   assign bus.cpu_gnt = gnt_any & (sel_port == PORT_CPU);
   assign bus.dma_gnt = gnt_any & (sel_port == PORT_DMA);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         burst_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         load_q  <= 1'b0;
      end else begin
         load_q <= gnt_any & sel_we;
         if (gnt_any) begin
            addr_q <= sel_addr;
            if (sel_we) begin
               wdata_q <= sel_wdata;
            end
            if (state_q == own_state(sel_port)) begin
               if (burst_q < BURST_MAX) begin
                  burst_q <= burst_q + 1'b1;
               end
            end else begin
               state_q <= own_state(sel_port);
               burst_q <= CW'(1);
            end
         end else if (!sel_vld) begin
            state_q <= ST_IDLE;
            burst_q <= '0;
         end
      end
   end

   rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tags (
      .clk          (clk),
      .rst_n        (reset),
      .push_i       (gnt_any & ~sel_we),
      .port_i       (sel_port),
      .cpu_rvalid_o (cpu_rv),
      .dma_rvalid_o (dma_rv),
      .busy_o       (rd_busy)
   );

   assign bus.cpu_rvalid  = cpu_rv;
   assign bus.dma_rvalid  = dma_rv;
   assign bus.cpu_rdata   = bus.mem_out;
   assign bus.dma_rdata   = bus.mem_out;
   assign bus.mem_in      = wdata_q;
   assign bus.mem_load    = load_q;
   assign bus.mem_address = addr_q;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Bench for hack_mem_arbiter: directed scenarios plus random traffic.
// Checked each cycle against a transaction-level model.
module tb_hack_mem_arbiter;
   import hack_mem_pkg::*;

   localparam int RD_LAT    = 1;
   localparam int MAX_BURST = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   hack_mem_arbiter_if bus ();

   hack_mem_arbiter #(
      .RD_LAT    (RD_LAT),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_word(logic [14:0] a);
      return {1'b0, a} ^ 16'hA5A5;
   endfunction

   // Memory block: registered read, output frozen while load is high.
   logic [15:0] ram [32768];
   bit          seen [32768];
   logic [15:0] mem_q = 16'h0000;

   always @(posedge clk) begin
      if (bus.mem_load) begin
         if (bus.mem_address != KBD_ADDR) begin
            ram[bus.mem_address]  <= bus.mem_in;
            seen[bus.mem_address] <= 1'b1;
         end
      end else if (bus.mem_address == KBD_ADDR) begin
         mem_q <= 16'h0041;
      end else begin
         mem_q <= seen[bus.mem_address] ? ram[bus.mem_address]
                                        : init_word(bus.mem_address);
      end
   end

   assign bus.mem_out = mem_q;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state.
   typedef struct {
      int          port;
      longint      due;
      logic [15:0] data;
   } rd_t;

   rd_t         rq [$];
   logic [15:0] shadow [int];
   int          own = -1;
   int          run = 0;
   longint      cyc = 0;
   logic        exp_load = 1'b0;
   logic [14:0] exp_addr = '0;
   logic [15:0] exp_in   = '0;

   function automatic logic [15:0] shadow_rd(logic [14:0] a);
      if (a == KBD_ADDR) return 16'h0041;
      if (shadow.exists(int'(a))) return shadow[int'(a)];
      return init_word(a);
   endfunction

   // Stimulus drive values.
   logic [1:0]  d_req = '0;
   logic [1:0]  d_we  = '0;
   logic [14:0] d_addr [2];
   logic [15:0] d_wdata [2];
   logic        d_rst = 1'b0;

   // Observations from the last step.
   int          hs;
   logic [1:0]  rv_seen;
   logic [15:0] rv_data [2];

   task automatic step();
      int  p;
      bit  blocked;
      bit  e;
      @(negedge clk);
      bus.cpu_req   = d_req[0];
      bus.cpu_we    = d_we[0];
      bus.cpu_addr  = d_addr[0];
      bus.cpu_wdata = d_wdata[0];
      bus.dma_req   = d_req[1];
      bus.dma_we    = d_we[1];
      bus.dma_addr  = d_addr[1];
      bus.dma_wdata = d_wdata[1];
      rst_n         = d_rst;
      #1;
      if (!rst_n) begin
         own = -1;
         run = 0;
         rq.delete();
         exp_load = 1'b0;
         exp_addr = '0;
         exp_in   = '0;
      end
      check("mem_load", 32'(bus.mem_load), 32'(exp_load));
      check("mem_address", 32'(bus.mem_address), 32'(exp_addr));
      check("mem_in", 32'(bus.mem_in), 32'(exp_in));
      rv_seen    = {bus.dma_rvalid, bus.cpu_rvalid};
      rv_data[0] = bus.cpu_rdata;
      rv_data[1] = bus.dma_rdata;
      for (int k = 0; k < 2; k++) begin
         e = (rq.size() > 0) && (rq[0].due == cyc) && (rq[0].port == k);
         check(k ? "dma_rvalid" : "cpu_rvalid", 32'(rv_seen[k]), 32'(e));
         if (e) begin
            check(k ? "dma_rdata" : "cpu_rdata",
                  32'(rv_data[k]), 32'(rq[0].data));
         end
      end
      p = -1;
      if (rst_n && d_req != 2'b00) begin
         if (own < 0)
            p = d_req[0] ? 0 : 1;
         else if (d_req[own] && (!d_req[1-own] || run < MAX_BURST))
            p = own;
         else
            p = 1 - own;
      end
      blocked = (p >= 0) && d_we[p] && (rq.size() > 0);
      hs = (p >= 0 && !blocked) ? p : -1;
      check("cpu_gnt", 32'(bus.cpu_gnt), 32'(hs == 0));
      check("dma_gnt", 32'(bus.dma_gnt), 32'(hs == 1));
      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      exp_load = 1'b0;
      if (hs >= 0) begin
         if (own == hs) begin
            if (run < MAX_BURST) run++;
         end else begin
            own = hs;
            run = 1;
         end
         exp_addr = d_addr[hs];
         if (d_we[hs]) begin
            exp_load = 1'b1;
            exp_in   = d_wdata[hs];
            if (d_addr[hs] != KBD_ADDR) shadow[int'(d_addr[hs])] = d_wdata[hs];
         end else begin
            rq.push_back('{hs, cyc + 1 + RD_LAT, shadow_rd(d_addr[hs])});
         end
      end else if (p < 0) begin
         own = -1;
         run = 0;
      end
      cyc++;
   endtask

   function automatic logic [14:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return SCREEN_BASE + 15'($urandom_range(0, 3));
         1:       return KBD_ADDR;
         default: return 15'($urandom_range(0, 7));
      endcase
   endfunction

   task automatic rand_reqs(int pct);
      for (int k = 0; k < 2; k++) begin
         if (d_req[k] && hs != k) begin
            if ($urandom_range(0, 15) == 0) d_req[k] = 1'b0;
         end else begin
            d_req[k]   = ($urandom_range(0, 99) < pct);
            d_we[k]    = ($urandom_range(0, 2) == 0);
            d_addr[k]  = pick_addr();
            d_wdata[k] = 16'($urandom);
         end
      end
   endtask

   task automatic idle(int n);
      d_req = 2'b00;
      for (int i = 0; i < n; i++) step();
   endtask

   int gseq [12];
   int cnt [2];
   int gi;
   int first_rv;
   int last_rv;
   logic [15:0] kbd_data;

   initial begin
      d_addr[0]  = '0;
      d_addr[1]  = '0;
      d_wdata[0] = '0;
      d_wdata[1] = '0;

      // Reset held with both ports requesting reads.
      d_rst = 1'b0;
      d_req = 2'b11;
      d_we  = 2'b00;
      for (int i = 0; i < 3; i++) step();
      d_rst = 1'b1;
      step();
      check("first_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
      idle(4);

      // CPU write to screen then read it back.
      d_req = 2'b01;
      d_we  = 2'b01;
      d_addr[0]  = SCREEN_BASE;
      d_wdata[0] = 16'h1234;
      step();
      d_req = 2'b00;
      step();
      check("wr_load", 32'(bus.mem_load), 32'd1);
      check("wr_addr", 32'(bus.mem_address), 32'h4000);
      check("wr_data", 32'(bus.mem_in), 32'h1234);
      d_req = 2'b01;
      d_we  = 2'b00;
      step();
      d_req = 2'b00;
      step();
      step();
      check("rb_rvalid", 32'(rv_seen[0]), 32'd1);
      check("rb_data", 32'(rv_data[0]), 32'h1234);
      idle(3);

      // Bounded burst with both ports streaming reads.
      d_req = 2'b11;
      d_we  = 2'b00;
      d_addr[0] = 15'd2;
      d_addr[1] = 15'd3;
      cnt[0] = 0;
      cnt[1] = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         gseq[i] = bus.dma_gnt ? 1 : (bus.cpu_gnt ? 0 : -1);
         cnt[0] += int'(rv_seen[0]);
         cnt[1] += int'(rv_seen[1]);
      end
      for (int i = 0; i < 12; i++) begin
         check($sformatf("burst_gnt%0d", i), 32'(gseq[i]), 32'((i / 4) % 2));
      end
      d_req = 2'b00;
      for (int i = 0; i < 4; i++) begin
         step();
         cnt[0] += int'(rv_seen[0]);
         cnt[1] += int'(rv_seen[1]);
      end
      check("burst_cpu_rv", 32'(cnt[0]), 32'd8);
      check("burst_dma_rv", 32'(cnt[1]), 32'd4);

      // Write hazard behind a DMA keyboard read.
      d_req = 2'b10;
      d_we  = 2'b00;
      d_addr[1] = KBD_ADDR;
      step();
      d_req = 2'b01;
      d_we  = 2'b01;
      d_addr[0]  = 15'd3;
      d_wdata[0] = 16'hBEEF;
      gi = 99;
      kbd_data = '0;
      for (int i = 0; i < 8 && gi == 99; i++) begin
         step();
         if (rv_seen[1]) kbd_data = rv_data[1];
         if (bus.cpu_gnt) gi = i;
      end
      check("haz_gnt_step", 32'(gi), 32'd2);
      check("haz_kbd", 32'(kbd_data), 32'h0041);
      idle(3);

      // Reset one cycle after a read handshake.
      d_req = 2'b01;
      d_we  = 2'b00;
      d_addr[0] = 15'd5;
      step();
      d_req = 2'b00;
      d_rst = 1'b0;
      cnt[0] = 0;
      step();
      check("rst_mid_addr", 32'(bus.mem_address), 32'd0);
      cnt[0] += int'(rv_seen[0]);
      step();
      cnt[0] += int'(rv_seen[0]);
      d_rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         cnt[0] += int'(rv_seen[0]);
      end
      check("rst_mid_no_rv", 32'(cnt[0]), 32'd0);

      // DMA alone streams ten reads.
      cnt[1] = 0;
      first_rv = -1;
      last_rv  = -1;
      d_we = 2'b00;
      for (int i = 0; i < 14; i++) begin
         d_req = (i < 10) ? 2'b10 : 2'b00;
         d_addr[1] = 15'(i < 10 ? i : 9);
         step();
         if (i < 10) cnt[0] += int'(bus.dma_gnt);
         if (rv_seen[1]) begin
            if (first_rv < 0) first_rv = i;
            last_rv = i;
            check($sformatf("stream_data%0d", cnt[1]),
                  32'(rv_data[1]), 32'(shadow_rd(15'(cnt[1]))));
            cnt[1]++;
         end
      end
      check("stream_gnts", 32'(cnt[0]), 32'd10);
      check("stream_rvs", 32'(cnt[1]), 32'd10);
      check("stream_span", 32'(last_rv - first_rv), 32'd9);

      // Random mixed traffic.
      hs = -1;
      d_req = 2'b00;
      for (int i = 0; i < 3000; i++) begin
         rand_reqs(i < 1500 ? 60 : 90);
         step();
      end
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
